// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer
//   Retunes PLL 0 through the reconfiguration block's Avalon-MM management
//   slave. One request carries new N, M and C0 counter words. The sequencer
//   writes mode, N, M, C0 and START, then polls status until done. It then
//   waits for a stable synchronized lock and returns a one-cycle response
//   with a result code.
//
// Ports
//   clk_clk, reset_reset      : clock, asynchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only when idle)
//   req_n/req_m/req_c0        : 18-bit counter words {odd, bypass, hi[7:0], lo[7:0]}
//   rsp_valid/rsp_status      : completion pulse; 0 ok, 1 reconfig timeout, 2 lock timeout
//   busy                      : request accepted and not yet responded
//   mgmt_*                    : Avalon-MM master toward pll_reconfig_0
//   pll_locked                : raw PLL lock, asynchronous to clk_clk
module pll_reconfig_sequencer #(
    parameter int POLL_LIMIT   = 1024,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_STABLE  = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [17:0] req_n,
    input  logic [17:0] req_m,
    input  logic [17:0] req_c0,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_MAX   = PW'(POLL_LIMIT);
    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_START,
        S_RD_STATUS, S_POLL_GAP, S_WAIT_LOCK, S_RESP
    } state_t;

    state_t        state_q;
    logic [17:0]   n_q, m_q, c0_q;
    logic [PW-1:0] poll_q, poll_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          req_ready_q, busy_q, rsp_valid_q;
    logic [1:0]    rsp_status_q;
    logic [5:0]    addr_q;
    logic [31:0]   wdata_q;
    logic          mwr_q, mrd_q;
    logic          lock_meta_q, lock_sync_q;
    logic          wr_done, rd_done, lock_hit, tmo_hit;

    // Only the done bit of the status word is meaningful.
    logic unused_ok;
    assign unused_ok = ^mgmt_readdata[31:1];

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // An access completes on the edge where the strobe is seen without a stall.
    assign wr_done = mwr_q & ~mgmt_waitrequest;
    assign rd_done = mrd_q & ~mgmt_waitrequest;

    // Saturating next values; a dropout in lock restarts the stability run.
    always_comb begin
        poll_d   = (poll_q == POLL_MAX) ? poll_q : poll_q + PW'(1);
        tmo_d    = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
        stable_d = '0;
        if (lock_sync_q)
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
        lock_hit = (stable_d == STABLE_MAX);
        tmo_hit  = (tmo_d == TMO_MAX);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            m_q          <= '0;
            c0_q         <= '0;
            poll_q       <= '0;
            stable_q     <= '0;
            tmo_q        <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mwr_q        <= 1'b0;
            mrd_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        n_q         <= req_n;
                        m_q         <= req_m;
                        c0_q        <= req_c0;
                        poll_q      <= '0;
                        stable_q    <= '0;
                        tmo_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        mwr_q       <= 1'b1;
                        addr_q      <= 6'h00;
                        wdata_q     <= 32'd1;          // polling mode
                        state_q     <= S_WR_MODE;
                    end
                end
                S_WR_MODE: begin
                    if (wr_done) begin
                        addr_q  <= 6'h03;
                        wdata_q <= {14'b0, n_q};
                        state_q <= S_WR_N;
                    end
                end
                S_WR_N: begin
                    if (wr_done) begin
                        addr_q  <= 6'h04;
                        wdata_q <= {14'b0, m_q};
                        state_q <= S_WR_M;
                    end
                end
                S_WR_M: begin
                    if (wr_done) begin
                        addr_q  <= 6'h05;
                        wdata_q <= {9'b0, 5'd0, c0_q};  // [22:18] selects C0
                        state_q <= S_WR_C0;
                    end
                end
                S_WR_C0: begin
                    if (wr_done) begin
                        addr_q  <= 6'h02;
                        wdata_q <= 32'd1;
                        state_q <= S_WR_START;
                    end
                end
                S_WR_START: begin
                    if (wr_done) begin
                        mwr_q   <= 1'b0;
                        mrd_q   <= 1'b1;
                        addr_q  <= 6'h01;
                        state_q <= S_RD_STATUS;
                    end
                end
                S_RD_STATUS: begin
                    if (rd_done) begin
                        poll_q <= poll_d;
                        mrd_q  <= 1'b0;
                        if (mgmt_readdata[0]) begin
                            state_q <= S_WAIT_LOCK;
                        end else if (poll_d == POLL_MAX) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= 2'd1;
                            state_q      <= S_RESP;
                        end else begin
                            state_q <= S_POLL_GAP;
                        end
                    end
                end
                S_POLL_GAP: begin
                    mrd_q   <= 1'b1;
                    state_q <= S_RD_STATUS;
                end
                S_WAIT_LOCK: begin
                    stable_q <= stable_d;
                    tmo_q    <= tmo_d;
                    // Lock is tested first so it wins a same-cycle tie.
                    if (lock_hit) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'd0;
                        state_q      <= S_RESP;
                    end else if (tmo_hit) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'd2;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    mwr_q       <= 1'b0;
                    mrd_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign busy           = busy_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_status     = rsp_status_q;
    assign mgmt_address   = addr_q;
    assign mgmt_write     = mwr_q;
    assign mgmt_read      = mrd_q;
    assign mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
module tb_pll_reconfig_sequencer;

    localparam int PL = 8;
    localparam int LT = 100;
    localparam int LS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [17:0] req_n = '0, req_m = '0, req_c0 = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;

    pll_reconfig_sequencer #(.POLL_LIMIT(PL), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_m(req_m), .req_c0(req_c0),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .busy(busy),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave / environment configuration for the current transaction.
    int zeros_cfg = 0;   // status reads returning done=0 before done=1
    int stall_en  = 0;
    int lock_mode = 0;   // 0 held high, 1 toggles every 10 cycles
    int hold_wr_m = 0;   // stall the M write forever
    int rd_cnt = 0, stall_cycles = 0, tog_cnt = 0, stall_left = 0;
    bit new_acc = 1'b1, prev_stall = 1'b0;
    logic [39:0] prev_bus;
    logic [5:0]  q_addr[$];
    logic [31:0] q_data[$];
    bit          q_wr[$];

    // Avalon slave responder and lock driver; acts between clock edges.
    always @(negedge clk) begin
        logic [31:0] rdv;
        if (lock_mode == 1) begin
            if (tog_cnt == 9) begin pll_locked = ~pll_locked; tog_cnt = 0; end
            else tog_cnt++;
        end else begin
            pll_locked = 1'b1;
        end
        if (rst) begin
            mgmt_waitrequest = 1'b0;
            prev_stall = 1'b0;
            new_acc = 1'b1;
        end else begin
            if (mgmt_write || mgmt_read)
                chk("one_strobe", {mgmt_write, mgmt_read}, (mgmt_write ? 2'b10 : 2'b01));
            if (prev_stall)
                chk("stall_stable", {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, prev_bus);
            prev_bus = {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
            if (hold_wr_m != 0 && mgmt_write && mgmt_address == 6'd4) begin
                mgmt_waitrequest = 1'b1;
                prev_stall = 1'b1;
            end else if (mgmt_write || mgmt_read) begin
                if (new_acc) begin
                    stall_left = (stall_en != 0) ? int'($urandom_range(1, 3)) : 0;
                    new_acc = 1'b0;
                end
                if (stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                    stall_cycles++;
                    prev_stall = 1'b1;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    prev_stall = 1'b0;
                    new_acc = 1'b1;
                    q_addr.push_back(mgmt_address);
                    q_data.push_back(mgmt_writedata);
                    q_wr.push_back(mgmt_write);
                    if (mgmt_read) begin
                        rdv = $urandom;
                        rdv[0] = (rd_cnt >= zeros_cfg);
                        mgmt_readdata = rdv;
                        rd_cnt++;
                    end
                end
            end else begin
                mgmt_waitrequest = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    // Issue one request at the current negedge and check the whole exchange.
    // e_lat is the latency without stalls; each stalled cycle adds one.
    task automatic run_txn(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0,
                           input int zeros, input int st, input int lm, input int junk,
                           input logic [1:0] e_st, input int e_reads, input int e_lat,
                           input string tag);
        int cyc, guard;
        logic [5:0]  ea[5];
        logic [31:0] ew[5];
        zeros_cfg = zeros; stall_en = st; lock_mode = lm;
        rd_cnt = 0; stall_cycles = 0;
        q_addr.delete(); q_data.delete(); q_wr.delete();
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
        chk({tag, "_ready"}, req_ready, 1);
        req_n = n; req_m = m; req_c0 = c0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        chk({tag, "_accept"}, {busy, req_ready, mgmt_write, mgmt_address}, {1'b1, 1'b0, 1'b1, 6'd0});
        while (!rsp_valid && cyc < 3000) begin
            if (junk != 0) begin
                req_valid = 1'($urandom_range(0, 1));
                req_n = 18'($urandom); req_m = 18'($urandom); req_c0 = 18'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        chk({tag, "_rsp_seen"}, rsp_valid, 1);
        chk({tag, "_lat"}, cyc, e_lat + stall_cycles);
        chk({tag, "_status"}, rsp_status, e_st);
        chk({tag, "_nacc"}, q_addr.size(), 5 + e_reads);
        ea = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h02};
        ew = '{32'd1, {14'b0, n}, {14'b0, m}, {9'b0, 5'd0, c0}, 32'd1};
        for (int i = 0; i < 5; i++)
            if (i < q_addr.size())
                chk({tag, "_wr"}, {q_wr[i], q_addr[i], q_data[i]}, {1'b1, ea[i], ew[i]});
        for (int i = 5; i < q_addr.size(); i++)
            chk({tag, "_rd"}, {q_wr[i], q_addr[i]}, {1'b0, 6'h01});
        @(negedge clk);
        chk({tag, "_post"}, {rsp_valid, busy, req_ready, rsp_status}, {1'b0, 1'b0, 1'b1, e_st});
    endtask

    typedef struct {
        logic [17:0] n, m, c0;
        int          zeros;
        int          lm;
        logic [1:0]  st;
        int          reads;
        int          lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [17:0] rn, rm, rc;
        int z, e_reads, e_lat, guard;
        logic [1:0] e_st;

        // Expected values from the cycle budget: 5 writes, then a status read
        // every other cycle, then LOCK_STABLE or LOCK_TIMEOUT cycles, then RESP.
        tbl[0] = '{18'h00404, 18'h01010, 18'h00202, 0,  0, 2'd0, 1, 23};   // nominal
        tbl[1] = '{18'h00404, 18'h01010, 18'h00202, 4,  0, 2'd0, 5, 31};   // polling
        tbl[2] = '{18'h00123, 18'h01ABC, 18'h00F0F, 7,  0, 2'd0, 8, 37};   // done on last poll
        tbl[3] = '{18'h3FFFF, 18'h2AAAA, 18'h15555, 0,  0, 2'd0, 1, 23};   // all format bits
        tbl[4] = '{18'h00404, 18'h01010, 18'h00202, 99, 0, 2'd1, 8, 21};   // reconfig timeout
        tbl[5] = '{18'h00404, 18'h01010, 18'h00202, 0,  1, 2'd2, 1, 107};  // lock timeout

        #1 rst = 1'b1;
        #3;
        chk("reset_state",
            {req_ready, busy, rsp_valid, rsp_status, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata},
            {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 6'd0, 32'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Back-to-back: each row starts in the cycle after the previous response.
        for (int i = 0; i < 6; i++)
            run_txn(tbl[i].n, tbl[i].m, tbl[i].c0, tbl[i].zeros, 0, tbl[i].lm, 0,
                    tbl[i].st, tbl[i].reads, tbl[i].lat, "tbl");
        lock_mode = 0;

        // Reset while the M write is stalled.
        hold_wr_m = 1; zeros_cfg = 0; stall_en = 0;
        req_n = 18'h00404; req_m = 18'h01010; req_c0 = 18'h00202; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!(mgmt_write && mgmt_address == 6'd4) && guard < 50) begin @(negedge clk); guard++; end
        chk("rst_wrm_seen", {mgmt_write, mgmt_address}, {1'b1, 6'd4});
        @(negedge clk);
        chk("rst_wrm_held", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, 6'd4, 32'h01010});
        #2 rst = 1'b1;
        #1;
        chk("rst_async",
            {mgmt_write, mgmt_read, busy, rsp_valid, req_ready, rsp_status},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
        @(negedge clk);
        hold_wr_m = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release", {req_ready, busy, mgmt_write}, {1'b1, 1'b0, 1'b0});
        run_txn(18'h00404, 18'h01010, 18'h00202, 0, 0, 0, 1, 2'd0, 1, 23, "post_rst");

        // Randomized words, poll depth and stalls against the reference budget.
        for (int k = 0; k < 8; k++) begin
            rn = 18'($urandom); rm = 18'($urandom); rc = 18'($urandom);
            z = int'($urandom_range(0, 10));
            e_reads = (z < PL) ? z + 1 : PL;
            e_st    = (z < PL) ? 2'd0 : 2'd1;
            e_lat   = 5 + 2 * e_reads - 1 + ((e_st == 2'd0) ? LS : 0) + 1;
            run_txn(rn, rm, rc, z, 1, 0, (k % 2), e_st, e_reads, e_lat, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_sequencer.md
# pll_reconfig_sequencer

Hardware sequencer that retunes PLL 0 at runtime through the PLL reconfiguration block's Avalon-MM management slave. It takes one request holding new N, M and C0 counter words and issues the full register write sequence. It then polls reconfiguration status, waits for stable PLL lock, and returns a one-cycle response with a result code. It sits between the host-side control path (CPU/GPIO) and `pll_reconfig_0`, so software never drives the management bus directly.

## Interface
- `POLL_LIMIT`, 1024: maximum status reads after START before reporting a reconfig timeout.
- `LOCK_TIMEOUT`, 1000000: maximum cycles in lock wait before reporting a lock timeout.
- `LOCK_STABLE`, 16: consecutive synchronized-locked cycles required to declare lock.

Ports:
- `clk_clk` in 1: sole clock.
- `reset_reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: high only in IDLE.
- `req_n` in 18: N counter word ([7:0] low, [15:8] high, [16] bypass, [17] odd).
- `req_m` in 18: M counter word, same format.
- `req_c0` in 18: C0 counter word, same format.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_status` out 2: 0 ok, 1 reconfig timeout, 2 lock timeout; held until next `rsp_valid`.
- `busy` out 1: high from request accept through `rsp_valid`.
- `mgmt_address` out 6: management word address.
- `mgmt_write` out 1: write strobe.
- `mgmt_read` out 1: read strobe.
- `mgmt_writedata` out 32: write data.
- `mgmt_readdata` in 32: read data, valid when `mgmt_read & ~mgmt_waitrequest`.
- `mgmt_waitrequest` in 1: slave stall.
- `pll_locked` in 1: PLL lock, asynchronous to `clk_clk`.

## Operation
- Request handshake: the request is accepted on `req_valid & req_ready`, and the three words are registered. `req_valid` while busy is ignored and is not queued.
- FSM states: IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_START, RD_STATUS, POLL_GAP, WAIT_LOCK, RESP.
- Write sequence, one write per state; each write advances on `mgmt_write & ~mgmt_waitrequest`:
  - WR_MODE: addr 0x00, data 1 (polling mode).
  - WR_N: addr 0x03, data {14'b0, n}.
  - WR_M: addr 0x04, data {14'b0, m}.
  - WR_C0: addr 0x05, data {9'b0, 5'd0, c0}, where bits [22:18] = counter select 0.
  - WR_START: addr 0x02, data 1.
- RD_STATUS: read addr 0x01 and increment the poll count on completion.
  - If `readdata[0]` = 1, go to WAIT_LOCK.
  - Else if poll count = POLL_LIMIT, go to RESP with status 1.
  - Else go to POLL_GAP for one cycle with no strobe, then return to RD_STATUS.
- `pll_locked` passes through a 2-flop synchronizer.
- WAIT_LOCK:
  - A stable counter increments while synchronized lock is 1 and clears to 0 when it is 0.
  - Reaching LOCK_STABLE goes to RESP with status 0.
  - A timeout counter counts cycles in WAIT_LOCK. Reaching LOCK_TIMEOUT first goes to RESP with status 2.
  - If both limits are reached on the same cycle, lock wins (status 0).
- RESP: `rsp_valid` is 1 for one cycle, then the FSM returns to IDLE.
- Counter widths are $clog2(limit+1), and counters saturate with no wrap. Poll count, stable count and timeout count are cleared on request accept.
- Avalon rules:
  - At most one of `mgmt_write`/`mgmt_read` is high at a time.
  - Address, data and strobe stay stable while `mgmt_waitrequest` = 1.
  - Strobes drop in the cycle after completion unless the next state issues another access.
- Reset, asynchronous and valid at any time:
  - FSM goes to IDLE; all strobes, `rsp_valid` and `busy` go to 0; `rsp_status` goes to 0.
  - Any in-flight Avalon access is abandoned. `pll_reconfig_0` shares this reset.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_status`=0, `mgmt_write`=0, `mgmt_read`=0, `mgmt_address`=0, `mgmt_writedata`=0.
- All outputs are registered.
- After accept, WR_MODE strobes in the next cycle.
- With `mgmt_waitrequest`=0, each write takes 1 cycle, so the 5 writes occupy cycles 1–5 after accept.
- The first status read is in cycle 6.
- Minimum request-to-`rsp_valid` latency with status done on the first read and lock already stable: 6 + LOCK_STABLE + 1 cycles.
- `req_ready` reasserts the cycle after `rsp_valid`. A request presented in that cycle is accepted.

## Test plan
- Nominal: N=0x00404, M=0x01010, C0=0x00202, zero waitrequest, status=1 on the first read, locked held high.
  - Required: writes to 0,3,4,5,2 with data 1, 0x404, 0x1010, 0x202, 1.
  - Required: `rsp_valid` with status 0 exactly 6+16+1 cycles after accept.
- Waitrequest stretch: 3 random-length stalls per access. Required: strobes, address and data stable throughout every stall; same write order and data as nominal.
- Status polling: status reads 0 four times, then 1. Required: exactly 5 reads, each separated by one idle cycle; final status 0.
- Reconfig timeout: POLL_LIMIT=8, status stuck at 0. Required: exactly 8 reads, then `rsp_valid` with status 1 and no WAIT_LOCK entry.
- Lock timeout and glitch: LOCK_TIMEOUT=100. Locked toggles every 10 cycles and never holds 16 stable cycles. Required: `rsp_valid` with status 2 at 100 cycles.
- Reset mid-operation: assert reset while `mgmt_write` is high during WR_M with waitrequest=1. Required: strobe low immediately (asynchronous), `req_ready`=1 after release. A new request then completes nominally; `req_valid` pulses during busy are ignored.
